// File: rtl/cacheline_burst_responder_pkg.sv
// Shared types for the cache line port and the 64-bit main-memory burst port.
package cacheline_burst_responder_pkg;

  typedef logic [127:0] lc3b_cacheline;
  typedef logic [15:0]  lc3b_word;
  typedef logic [63:0]  lc3b_beat;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lc3b_pmem_state;

  // Byte offset of the second beat within a line.
  localparam lc3b_word BEAT_ADDR_OFFSET = 16'h0008;
  localparam lc3b_word LINE_ADDR_MASK   = 16'hFFF0;

  // Drop the byte-within-line bits so the burst always starts on a line boundary.
  function automatic lc3b_word line_align(input lc3b_word addr);
    return addr & LINE_ADDR_MASK;
  endfunction

endpackage

// File: rtl/cacheline_beat_buffer.sv
// 128-bit line register whose halves load independently; holds write data
// and collects the first read beat.
module cacheline_beat_buffer
  import cacheline_burst_responder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_lo,
  input  logic          load_hi,
  input  lc3b_beat      d_lo,
  input  lc3b_beat      d_hi,
  output lc3b_cacheline q
);

  lc3b_cacheline line_r;

  // Per-half load of the line register; reset clears both halves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_r <= 128'h0;
    end else begin
      if (load_lo) begin
        line_r[63:0] <= d_lo;
      end
      if (load_hi) begin
        line_r[127:64] <= d_hi;
      end
    end
  end

  assign q = line_r;

endmodule

// File: rtl/cacheline_burst_responder.sv
// Turns one 128-bit line read/write from the cache into a two-beat 64-bit
// burst on main memory and returns a one-cycle completion pulse.
module cacheline_burst_responder
  import cacheline_burst_responder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_word      pmem_address,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_cacheline pmem_wdata,
  output lc3b_cacheline pmem_rdata,
  output logic          pmem_resp,
  output lc3b_word      mem_address,
  output logic          mem_req,
  output logic          mem_we,
  output lc3b_beat      mem_wdata,
  input  lc3b_beat      mem_rdata,
  input  logic          mem_ack
);

  lc3b_pmem_state state_r;
  lc3b_pmem_state next_state_s;
  logic           accept_s;
  logic           beat0_done_s;
  logic           beat1_done_s;
  logic           buf_load_lo_s;
  lc3b_beat       buf_d_lo_s;
  lc3b_cacheline  line_buf_s;

  logic           mem_req_r;
  logic           mem_we_r;
  lc3b_word       mem_address_r;
  lc3b_beat       mem_wdata_r;
  logic           pmem_resp_r;
  lc3b_cacheline  pmem_rdata_r;

  // Next-state decode; acks outside the two beat states are ignored.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    beat0_done_s = 1'b0;
    beat1_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          next_state_s = BEAT0;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          next_state_s = BEAT1;
          beat0_done_s = 1'b1;
        end else begin
          next_state_s = BEAT0;
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          next_state_s = RESP;
          beat1_done_s = 1'b1;
        end else begin
          next_state_s = BEAT1;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Low half takes the write line on accept, or the first read beat on its ack.
  always_comb begin
    buf_load_lo_s = accept_s || (beat0_done_s && !mem_we_r);
    if (accept_s) begin
      buf_d_lo_s = pmem_wdata[63:0];
    end else begin
      buf_d_lo_s = mem_rdata;
    end
  end

  cacheline_beat_buffer u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_lo (buf_load_lo_s),
    .load_hi (accept_s),
    .d_lo    (buf_d_lo_s),
    .d_hi    (pmem_wdata[127:64]),
    .q       (line_buf_s)
  );

  // State register plus Moore request/response flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      pmem_resp_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      mem_req_r   <= (next_state_s == BEAT0) || (next_state_s == BEAT1);
      pmem_resp_r <= (next_state_s == RESP);
    end
  end

  // Beat address/data/direction: set up on accept, advanced to the high beat on the first ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_r      <= 1'b0;
      mem_address_r <= 16'h0;
      mem_wdata_r   <= 64'h0;
    end else if (accept_s) begin
      mem_we_r      <= pmem_write;
      mem_address_r <= line_align(pmem_address);
      mem_wdata_r   <= pmem_wdata[63:0];
    end else if (beat0_done_s) begin
      mem_address_r <= mem_address_r | BEAT_ADDR_OFFSET;
      mem_wdata_r   <= line_buf_s[127:64];
    end
  end

  // Publish the assembled line only when a read completes; writes leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmem_rdata_r <= 128'h0;
    end else if (beat1_done_s && !mem_we_r) begin
      pmem_rdata_r <= {mem_rdata, line_buf_s[63:0]};
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_address = mem_address_r;
  assign mem_wdata   = mem_wdata_r;
  assign pmem_resp   = pmem_resp_r;
  assign pmem_rdata  = pmem_rdata_r;

endmodule

// File: tb/tb_cacheline_burst_responder.sv
// Scoreboard bench: stimulus pushes expected beats/responses, a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_cacheline_burst_responder;
  import cacheline_burst_responder_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  lc3b_word      pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_cacheline pmem_wdata;
  lc3b_cacheline pmem_rdata;
  logic          pmem_resp;
  lc3b_word      mem_address;
  logic          mem_req;
  logic          mem_we;
  lc3b_beat      mem_wdata;
  lc3b_beat      mem_rdata;
  logic          mem_ack;

  typedef struct {
    lc3b_word addr;
    logic     we;
    lc3b_beat wdata;
    int       len;
  } beat_t;

  beat_t         beat_q[$];
  lc3b_cacheline resp_q[$];
  lc3b_cacheline model_rdata;

  int       pass_cnt  = 0;
  int       total_cnt = 0;
  int       wait_cfg  = 0;
  int       wait_ctr  = 0;
  logic     stray_ack = 1'b0;
  lc3b_beat rd_lo     = 64'h0;
  lc3b_beat rd_hi     = 64'h0;

  cacheline_burst_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: ack after wait_cfg wait cycles, data selected by beat address.
  assign mem_ack   = (mem_req && (wait_ctr == wait_cfg)) || stray_ack;
  assign mem_rdata = mem_address[3] ? rd_hi : rd_lo;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_ctr <= wait_ctr + 1;
    else                     wait_ctr <= 0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares every beat cycle against the queue head, pops on ack / resp.
  initial begin
    int req_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_len = 0;
      end else begin
        if (mem_req) begin
          if (beat_q.size() == 0) begin
            check("unexpected_beat", 128'(mem_address), 128'hFFFF_FFFF);
          end else begin
            req_len++;
            check("mem_address", 128'(mem_address), 128'(beat_q[0].addr));
            check("mem_we", 128'(mem_we), 128'(beat_q[0].we));
            check("mem_wdata", 128'(mem_wdata), 128'(beat_q[0].wdata));
            if (mem_ack) begin
              check("mem_req_cycles", 128'(req_len), 128'(beat_q[0].len));
              void'(beat_q.pop_front());
              req_len = 0;
            end
          end
        end
        if (pmem_resp) begin
          if (resp_q.size() == 0) begin
            check("unexpected_resp", 128'(pmem_resp), 128'h0);
          end else begin
            check("pmem_rdata", pmem_rdata, resp_q[0]);
            void'(resp_q.pop_front());
          end
        end
      end
    end
  end

  // One line transaction: queue expectations, drive request, measure latency.
  task automatic run_burst(input bit rd, input bit wr, input lc3b_word addr,
                           input lc3b_cacheline wd, input int waits,
                           input lc3b_beat lo, input lc3b_beat hi, input bit drop_mid);
    int n;
    bit got;
    lc3b_word base;
    base = addr & 16'hFFF0;
    beat_q.push_back('{addr: base,           we: wr, wdata: wd[63:0],   len: waits + 1});
    beat_q.push_back('{addr: base | 16'h0008, we: wr, wdata: wd[127:64], len: waits + 1});
    if (!wr) model_rdata = {hi, lo};
    resp_q.push_back(model_rdata);
    @(posedge clk); #1;
    wait_cfg     = waits;
    rd_lo        = lo;
    rd_hi        = hi;
    pmem_address = addr;
    pmem_wdata   = wd;
    pmem_read    = rd;
    pmem_write   = wr;
    n   = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      if (pmem_resp) begin
        got = 1'b1;
      end else begin
        if (drop_mid && n == waits + 2) begin
          pmem_read  = 1'b0;
          pmem_write = 1'b0;
        end
        n++;
      end
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL resp_timeout: no pmem_resp within %0d cycles", n);
    end else begin
      check("resp_latency", 128'(n), 128'(3 + 2 * waits));
    end
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    model_rdata  = 128'h0;
    rst_n        = 1'b0;
    pmem_address = 16'h0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 128'(mem_req), 128'h0);
    check("rst_mem_we", 128'(mem_we), 128'h0);
    check("rst_mem_address", 128'(mem_address), 128'h0);
    check("rst_mem_wdata", 128'(mem_wdata), 128'h0);
    check("rst_pmem_resp", 128'(pmem_resp), 128'h0);
    check("rst_pmem_rdata", pmem_rdata, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero-wait read at 0x1234.
    run_burst(1'b1, 1'b0, 16'h1234, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, 0,
              64'hAAAA_AAAA_AAAA_0001, 64'hBBBB_BBBB_BBBB_0002, 1'b0);
    check("read0_rdata_hold", pmem_rdata, 128'hBBBB_BBBB_BBBB_0002_AAAA_AAAA_AAAA_0001);

    // Write with two wait cycles per beat; rdata stays.
    run_burst(1'b0, 1'b1, 16'h00F0, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 2,
              64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0002, 1'b0);
    check("write_rdata_kept", pmem_rdata, 128'hBBBB_BBBB_BBBB_0002_AAAA_AAAA_AAAA_0001);

    // Read and write together -> write burst.
    run_burst(1'b1, 1'b1, 16'h4A5C, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 1,
              64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);

    // Read dropped during BEAT1 still completes once.
    run_burst(1'b1, 1'b0, 16'h8008, 128'h0, 1,
              64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004, 1'b1);
    check("drop_rdata", pmem_rdata, 128'h4444_0000_0000_0004_3333_0000_0000_0003);

    // Stray ack in IDLE.
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_mem_req", 128'(mem_req), 128'h0);
    check("stray_pmem_resp", 128'(pmem_resp), 128'h0);
    check("stray_rdata", pmem_rdata, 128'h4444_0000_0000_0004_3333_0000_0000_0003);

    // Reset during BEAT0 wait.
    beat_q.push_back('{addr: 16'h2220, we: 1'b0, wdata: 64'h0, len: 0});
    @(posedge clk); #1;
    wait_cfg     = 5;
    pmem_address = 16'h2227;
    pmem_wdata   = 128'h0;
    pmem_read    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    pmem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat_q.delete();
    model_rdata = 128'h0;
    @(negedge clk);
    check("rstmid_mem_req", 128'(mem_req), 128'h0);
    check("rstmid_pmem_resp", 128'(pmem_resp), 128'h0);
    check("rstmid_pmem_rdata", pmem_rdata, 128'h0);
    check("rstmid_mem_address", 128'(mem_address), 128'h0);

    // Normal read after reset.
    run_burst(1'b1, 1'b0, 16'hFFFF, 128'h0, 0,
              64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718, 1'b0);

    repeat (5) @(negedge clk);
    check("beat_q_empty", 128'(beat_q.size()), 128'h0);
    check("resp_q_empty", 128'(resp_q.size()), 128'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
